// File: rtl/uart_rcvr.sv
// Oversampling 8-bit UART receiver: start/parity/stop validation, valid/ready byte output with error flags.
// Latency: commit one cycle after the last stop-bit mid sample (+2 cycles input sync). A frame finishing while output is held is dropped with an overrun pulse.
module uart_rcvr #(
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic [DIV_W-1:0] baud_div,
  input  logic             parity_en,
  input  logic             parity_odd,
  input  logic             two_stop,
  input  logic             rx,
  input  logic             rx_ready,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             parity_err,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] LAST = SW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e           state_q;
  logic             rx_meta_q, rx_s_q;
  logic [DIV_W-1:0] tick_cnt_q, tick_cnt_d, div_m1;
  logic [SW-1:0]    samp_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;
  logic             armed_q, busy_q, commit_q;
  logic             perr_n_q, ferr_n_q;
  logic             cfg_pe_q, cfg_odd_q, cfg_two_q;
  logic [7:0]       rx_data_q;
  logic             rx_valid_q, parity_err_q, frame_err_q, overrun_q;
  logic             tick, start_det, mid, last;

  // Synchroniser resets low so a line held low through reset cannot arm the receiver.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rx_meta_q <= 1'b0;
      rx_s_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  assign div_m1    = (baud_div == '0) ? '0 : baud_div - DIV_W'(1);
  assign tick      = (tick_cnt_q == '0);
  assign start_det = (state_q == IDLE) && armed_q && !rx_s_q;
  assign mid       = tick && (samp_q == MID);
  assign last      = tick && (samp_q == LAST);

  always_comb begin
    tick_cnt_d = tick_cnt_q - DIV_W'(1);
    if (start_det || tick) tick_cnt_d = div_m1;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) tick_cnt_q <= '0;
    else         tick_cnt_q <= tick_cnt_d;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q   <= IDLE;
      armed_q   <= 1'b0;
      samp_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      perr_n_q  <= 1'b0;
      ferr_n_q  <= 1'b0;
      cfg_pe_q  <= 1'b0;
      cfg_odd_q <= 1'b0;
      cfg_two_q <= 1'b0;
      busy_q    <= 1'b0;
      commit_q  <= 1'b0;
    end else begin
      commit_q <= 1'b0;
      if (state_q == IDLE) begin
        if (rx_s_q) armed_q <= 1'b1;
        if (start_det) begin
          state_q   <= START;
          busy_q    <= 1'b1;
          samp_q    <= '0;
          perr_n_q  <= 1'b0;
          ferr_n_q  <= 1'b0;
          cfg_pe_q  <= parity_en;
          cfg_odd_q <= parity_odd;
          cfg_two_q <= two_stop;
        end
      end else if (tick) begin
        samp_q <= last ? '0 : samp_q + SW'(1);
        case (state_q)
          START: begin
            if (mid && rx_s_q) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else if (last) begin
              state_q <= DATA;
              bit_q   <= '0;
            end
          end
          DATA: begin
            if (mid) shift_q[bit_q] <= rx_s_q;
            if (last) begin
              bit_q <= bit_q + 3'd1;
              if (bit_q == 3'd7) begin
                state_q <= cfg_pe_q ? PARITY : STOP;
                bit_q   <= '0;
              end
            end
          end
          PARITY: begin
            if (mid)  perr_n_q <= ((^shift_q) ^ rx_s_q) != cfg_odd_q;
            if (last) state_q  <= STOP;
          end
          STOP: begin
            if (mid) begin
              if (!rx_s_q) ferr_n_q <= 1'b1;
              // Leave half a bit early; a low stop keeps the receiver disarmed until the line idles.
              if (!cfg_two_q || bit_q == 3'd1) begin
                commit_q <= 1'b1;
                busy_q   <= 1'b0;
                state_q  <= IDLE;
                armed_q  <= rx_s_q;
              end
            end else if (last) begin
              bit_q <= 3'd1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (commit_q && (!rx_valid_q || rx_ready)) begin
        rx_data_q    <= shift_q;
        parity_err_q <= perr_n_q;
        frame_err_q  <= ferr_n_q;
        rx_valid_q   <= 1'b1;
      end else begin
        if (commit_q) overrun_q <= 1'b1;
        if (rx_valid_q && rx_ready) rx_valid_q <= 1'b0;
      end
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rcvr.sv
// Bench for uart_rcvr: directed frames plus randomized frames scored against a frame-level expectation queue.
module tb_uart_rcvr;

  logic        clk = 1'b0;
  logic        arst_n;
  logic [15:0] baud_div;
  logic        parity_en, parity_odd, two_stop, rx, rx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid, parity_err, frame_err, overrun, busy;

  uart_rcvr #(.OVERSAMPLE(16), .DIV_W(16)) dut (
    .clk(clk), .arst_n(arst_n), .baud_div(baud_div),
    .parity_en(parity_en), .parity_odd(parity_odd), .two_stop(two_stop),
    .rx(rx), .rx_ready(rx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   ovr_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int bit_cycles();
    return ((baud_div == 16'd0) ? 1 : int'(baud_div)) * 16;
  endfunction

  // Expected delivery derived from what was put on the line.
  task automatic model_push(input logic [7:0] d, input logic pe, input logic po,
                            input logic pb, input logic last_stop);
    exp_t e;
    e.d  = d;
    e.pe = pe && (pb != ((^d) ^ po));
    e.fe = !last_stop;
    exp_q.push_back(e);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic flip, input logic stop_low,
                            input int gap_bits, input logic expect_it);
    int   bp;
    logic pb;
    bp = bit_cycles();
    pb = parity_en ? ((^d) ^ parity_odd ^ flip) : 1'b0;
    if (expect_it) model_push(d, parity_en, parity_odd, pb, !stop_low);
    rx = 1'b0; cyc(bp);
    for (int i = 0; i < 8; i++) begin
      rx = d[i]; cyc(bp);
    end
    if (parity_en) begin
      rx = pb; cyc(bp);
    end
    if (two_stop) begin
      rx = 1'b1; cyc(bp);
    end
    rx = !stop_low; cyc(bp);
    rx = 1'b1;
    if (gap_bits > 0) cyc(gap_bits * bp);
  endtask

  task automatic wait_drain(input int max_cycles);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      cyc(1);
      n++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic set_cfg(input logic pe, input logic po, input logic ts);
    parity_en = pe; parity_odd = po; two_stop = ts;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (arst_n) begin
        if (overrun) ovr_cnt++;
        if (rx_valid && rx_ready) begin
          if (exp_q.size() == 0) begin
            chk("spurious_valid", 32'(rx_valid), 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("rx_data", 32'(rx_data), 32'(e.d));
            chk("parity_err", 32'(parity_err), 32'(e.pe));
            chk("frame_err", 32'(frame_err), 32'(e.fe));
          end
        end
      end
    end
  end

  initial begin
    logic [7:0] d;
    logic       flip, sl;
    int         gap;
    rx = 1'b1; rx_ready = 1'b1; baud_div = 16'd27; arst_n = 1'b0;
    set_cfg(1'b0, 1'b0, 1'b0);
    cyc(5);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_parity_err", 32'(parity_err), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    arst_n = 1'b1;
    cyc(20);

    send_frame(8'hA5, 1'b0, 1'b0, 1, 1'b1);
    wait_drain(100);

    baud_div = 16'd8;
    cyc(20);
    set_cfg(1'b1, 1'b0, 1'b0);
    send_frame(8'h53, 1'b1, 1'b0, 1, 1'b1);
    send_frame(8'h53, 1'b0, 1'b0, 1, 1'b1);
    wait_drain(100);

    set_cfg(1'b0, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b1, 2, 1'b1);
    send_frame(8'h3C, 1'b0, 1'b0, 1, 1'b1);
    wait_drain(100);

    rx = 1'b0; cyc(4 * 8);
    chk("glitch_busy_high", 32'(busy), 32'd1);
    rx = 1'b1; cyc(16 * 8);
    chk("glitch_busy_low", 32'(busy), 32'd0);
    chk("glitch_no_valid", 32'(rx_valid), 32'd0);
    send_frame(8'h81, 1'b0, 1'b0, 1, 1'b1);
    wait_drain(100);

    rx_ready = 1'b0;
    ovr_cnt  = 0;
    send_frame(8'h11, 1'b0, 1'b0, 0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b0, 1, 1'b0);
    cyc(10);
    chk("ovr_count", 32'(ovr_cnt), 32'd1);
    chk("ovr_valid_held", 32'(rx_valid), 32'd1);
    chk("ovr_data_held", 32'(rx_data), 32'h11);
    rx_ready = 1'b1;
    wait_drain(20);

    rx = 1'b0; cyc(3 * 128);
    #5 arst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_rx_data", 32'(rx_data), 32'd0);
    chk("arst_valid", 32'(rx_valid), 32'd0);
    cyc(3);
    arst_n = 1'b1;
    cyc(12 * 128);
    chk("unarmed_busy", 32'(busy), 32'd0);
    chk("unarmed_valid", 32'(rx_valid), 32'd0);
    rx = 1'b1; cyc(2 * 128);
    send_frame(8'hFF, 1'b0, 1'b0, 1, 1'b1);
    wait_drain(100);

    for (int n = 0; n < 100; n++) begin
      baud_div = 16'($urandom_range(0, 2));
      set_cfg(1'($urandom), 1'($urandom), 1'($urandom));
      d    = 8'($urandom);
      flip = ($urandom_range(0, 7) == 0);
      sl   = ($urandom_range(0, 7) == 0);
      gap  = sl ? 1 : $urandom_range(0, 2);
      send_frame(d, flip, sl, gap, 1'b1);
      wait_drain(100);
    end
    cyc(20);
    chk("final_queue", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
